// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and size decode for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request fields held for the duration of one access (address kept apart, it is parameterised).
  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  // Access size from funct3; unsupported encodings map to SZ_BAD.
  function automatic lsu_size_e size_of(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_BAD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and dmem word port bundled for lsu_ctrl.
interface lsu_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_is_load;
  logic              mem_is_store;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_store_data;
  logic [31:0]       mem_load_data;

  // Pipeline and dmem side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_load_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_is_load, mem_is_store, mem_addr, mem_store_data
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_load_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_is_load, mem_is_store, mem_addr, mem_store_data
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, sub-word store merge and,
// when LSU_MISALIGN_TRAP_EN is defined, misalignment detect.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] load_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_word
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  lsu_size_e   size;
  logic        is_signed;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign size      = size_of(funct3);
  assign is_signed = ~funct3[2];

  // Select the addressed lane of the loaded word and extend it.
  // Halfword lane uses addr[1] only, so a stray addr[0] is naturally ignored.
  always_comb begin
    byte_v   = load_word[{addr_lo, 3'b000} +: 8];
    half_v   = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    load_ext = '0;
    case (size)
      SZ_B:    load_ext = {{24{is_signed & byte_v[7]}}, byte_v};
      SZ_H:    load_ext = {{16{is_signed & half_v[15]}}, half_v};
      SZ_W:    load_ext = load_word;
      default: load_ext = '0;
    endcase
  end

  // Replace the addressed byte/halfword of the old word, keep the other lanes.
  always_comb begin
    store_word = load_word;
    case (size)
      SZ_B: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      SZ_W:    store_word = wdata;
      default: store_word = load_word;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword needs addr[0]=0, word needs addr[1:0]=0.
  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_H:    misalign = addr_lo[0];
      SZ_W:    misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a word-only dmem: sequences reads, writes and
// read-modify-write for sub-word stores. Optional LSU_MISALIGN_TRAP_EN turns
// misaligned halfword/word accesses into error responses instead of aligning.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned ADDR_W     = 32
) (
  input logic   clk,
  input logic   rst_n,
  lsu_if.slave  bus
);

  localparam int unsigned     CNT_W    = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_RD_LAT - 1);

  lsu_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wr_word_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;

  logic              accept;
  logic              reject;
  lsu_size_e         acc_size;
  logic [1:0]        sel_addr_lo;
  logic [2:0]        sel_funct3;
  logic [31:0]       load_ext;
  logic [31:0]       store_word;

  assign accept   = bus.req_valid & ready_q;
  assign acc_size = size_of(bus.req_funct3);

  // Lane logic looks at the incoming request in IDLE, the held one afterwards.
  assign sel_addr_lo = (state == IDLE) ? bus.req_addr[1:0] : addr_q[1:0];
  assign sel_funct3  = (state == IDLE) ? bus.req_funct3    : req_q.funct3;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;

  lsu_align u_align (
    .addr_lo    (sel_addr_lo),
    .funct3     (sel_funct3),
    .load_word  (bus.mem_load_data),
    .wdata      (req_q.wdata),
    .load_ext   (load_ext),
    .store_word (store_word),
    .misalign   (misalign)
  );

  assign reject = (acc_size == SZ_BAD) | misalign;
`else
  lsu_align u_align (
    .addr_lo    (sel_addr_lo),
    .funct3     (sel_funct3),
    .load_word  (bus.mem_load_data),
    .wdata      (req_q.wdata),
    .load_ext   (load_ext),
    .store_word (store_word)
  );

  assign reject = (acc_size == SZ_BAD);
`endif

  // State and read-latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: reads hold RD for MEM_RD_LAT cycles, sub-word stores continue into WR.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            state_n = RESP;
          end else if (bus.req_we && (acc_size == SZ_W)) begin
            state_n = WR;
          end else begin
            state_n = RD;
            cnt_n   = CNT_INIT;
          end
        end
      end
      RD: begin
        if (cnt == '0) state_n = req_q.we ? WR : RESP;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      WR:      state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Capture the request at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      addr_q <= '0;
    end else if (accept) begin
      req_q  <= '{we: bus.req_we, funct3: bus.req_funct3, wdata: bus.req_wdata};
      addr_q <= bus.req_addr;
    end
  end

  // Word to write: full store data for SW, merged read word for SB/SH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_word_q <= '0;
    end else if (accept) begin
      wr_word_q <= bus.req_wdata;
    end else if ((state == RD) && (state_n == WR)) begin
      wr_word_q <= store_word;
    end
  end

  // Registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      ready_q      <= (state_n == IDLE);
      resp_valid_q <= (state_n == RESP);
      resp_rdata_q <= ((state == RD) && (state_n == RESP)) ? load_ext : '0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Only rejected requests jump straight from IDLE to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state == IDLE) && (state_n == RESP);
  end

  assign bus.resp_err = err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

  // dmem strobes decoded from registered state; reset drops them immediately.
  assign bus.mem_is_load    = (state == RD);
  assign bus.mem_is_store   = (state == WR);
  assign bus.mem_addr       = ((state == RD) || (state == WR)) ? 32'(addr_q[ADDR_W-1:2]) : '0;
  assign bus.mem_store_data = (state == WR) ? wr_word_q : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a negedge-sampling word dmem model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic preload = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] dmem [0:255];

  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32)) bus ();

  lsu_ctrl #(.MEM_RD_LAT(1), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word memory: samples strobes on negedge, read data valid at the next posedge.
  always @(negedge clk) begin
    if (preload) begin
      dmem[8'h40] <= 32'h8899AABB;
      dmem[8'h41] <= 32'h0000_0000;
    end else if (bus.mem_is_store) begin
      dmem[bus.mem_addr[7:0]] <= bus.mem_store_data;
    end
    if (bus.mem_is_load) bus.mem_load_data <= dmem[bus.mem_addr[7:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request (called #1 after a posedge) and check timing and results.
  // Cycle k = the k-th cycle after the accept edge; exp_wr_cyc 0 means no write.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_resp, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_wr_cyc, input logic [31:0] exp_wr_data, input logic exp_rd);
    int          resp_cyc = 0;
    int          wr_cyc   = 0;
    int          wr_cnt   = 0;
    logic        rd_seen  = 1'b0;
    logic        err      = 1'b0;
    logic [31:0] rdata    = '0;
    logic [31:0] wdat     = '0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    check_eq({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 1; (k <= 8) && (resp_cyc == 0); k++) begin
      if (bus.mem_is_store) begin
        wr_cnt++;
        wr_cyc = k;
        wdat   = bus.mem_store_data;
      end
      if (bus.mem_is_load) rd_seen = 1'b1;
      if (bus.resp_valid) begin
        resp_cyc = k;
        rdata    = bus.resp_rdata;
        err      = bus.resp_err;
      end
      @(posedge clk);
      #1;
    end
    check_eq({tag, ".resp_cyc"}, 32'(resp_cyc), 32'(exp_resp));
    check_eq({tag, ".rdata"}, rdata, exp_rdata);
    check_eq({tag, ".err"}, 32'(err), 32'(exp_err));
    check_eq({tag, ".wr_cnt"}, 32'(wr_cnt), (exp_wr_cyc != 0) ? 32'd1 : 32'd0);
    check_eq({tag, ".wr_cyc"}, 32'(wr_cyc), 32'(exp_wr_cyc));
    if (exp_wr_cyc != 0) check_eq({tag, ".wr_data"}, wdat, exp_wr_data);
    check_eq({tag, ".rd_seen"}, 32'(rd_seen), 32'(exp_rd));
    check_eq({tag, ".resp_pulse"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    int wr_seen;
    int rv_seen;
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_funct3    = 3'b000;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.mem_load_data = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst.is_load", 32'(bus.mem_is_load), 32'd0);
    check_eq("rst.is_store", 32'(bus.mem_is_store), 32'd0);
    check_eq("rst.mem_addr", bus.mem_addr, 32'd0);
    preload = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // Loads from word 0x100 = 0x8899AABB
    do_req("lb",  1'b0, F3_B,  32'h101, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 0, 32'h0, 1'b1);
    do_req("lbu", 1'b0, F3_BU, 32'h101, 32'h0, 2, 32'h000000AA, 1'b0, 0, 32'h0, 1'b1);
    do_req("lh",  1'b0, F3_H,  32'h102, 32'h0, 2, 32'hFFFF8899, 1'b0, 0, 32'h0, 1'b1);
    do_req("lhu", 1'b0, F3_HU, 32'h102, 32'h0, 2, 32'h00008899, 1'b0, 0, 32'h0, 1'b1);
    do_req("lw",  1'b0, F3_W,  32'h100, 32'h0, 2, 32'h8899AABB, 1'b0, 0, 32'h0, 1'b1);

    // Sub-word stores: read-modify-write
    do_req("sb",  1'b1, F3_B,  32'h103, 32'h00000012, 3, 32'h0, 1'b0, 2, 32'h1299AABB, 1'b1);
    check_eq("sb.mem", dmem[8'h40], 32'h1299AABB);
    do_req("sh",  1'b1, F3_H,  32'h100, 32'hFFFF5555, 3, 32'h0, 1'b0, 2, 32'h12995555, 1'b1);
    check_eq("sh.mem", dmem[8'h40], 32'h12995555);

    // Full word store then back-to-back load of the same word
    do_req("sw",  1'b1, F3_W,  32'h104, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'hDEADBEEF, 1'b0);
    do_req("lw2", 1'b0, F3_W,  32'h104, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b1);
    check_eq("sw.mem", dmem[8'h41], 32'hDEADBEEF);

    // Signed byte with clear top bit
    do_req("lb3", 1'b0, F3_B,  32'h103, 32'h0, 2, 32'h00000012, 1'b0, 0, 32'h0, 1'b1);

    // Misaligned word: trap or aligned read of 0x100
    do_req("lw_mis", 1'b0, F3_W, 32'h102, 32'h0, TRAP ? 1 : 2,
           TRAP ? 32'h0 : 32'h12995555, TRAP, 0, 32'h0, !TRAP);

    // Unsupported funct3: no access, immediate response
    do_req("bad_ld", 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0, TRAP, 0, 32'h0, 1'b0);
    do_req("bad_st", 1'b1, 3'b110, 32'h104, 32'h11111111, 1, 32'h0, TRAP, 0, 32'h0, 1'b0);
    check_eq("bad_st.mem", dmem[8'h41], 32'hDEADBEEF);

    // Reset during the RD cycle of an SB aborts it
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h105;
    bus.req_wdata  = 32'h00000077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_eq("abort.in_rd", 32'(bus.mem_is_load), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort.load_drop", 32'(bus.mem_is_load), 32'd0);
    check_eq("abort.ready_rst", 32'(bus.req_ready), 32'd0);
    wr_seen = 0;
    rv_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) rst_n = 1'b1;
      if (bus.mem_is_store) wr_seen++;
      if (bus.resp_valid) rv_seen++;
      @(posedge clk);
      #1;
    end
    check_eq("abort.no_store", 32'(wr_seen), 32'd0);
    check_eq("abort.no_resp", 32'(rv_seen), 32'd0);
    check_eq("abort.ready", 32'(bus.req_ready), 32'd1);
    check_eq("abort.mem", dmem[8'h41], 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
